// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_iter
// Purpose  : Iterative AES-128 inverse cipher. One inverse round per clock.
//            Round keys are produced on the fly: forward expansion up to
//            rk10, then inverse expansion back down to rk0 while decrypting.
// Ports    : clk        - clock, all logic on posedge
//            rst_n      - synchronous active-low reset
//            in_data    - ciphertext, [127:120] = byte 0 (column-major)
//            key        - cipher key (round key 0), same byte order
//            flag       - start strobe, sampled only while busy = 0
//            data_out   - plaintext, held until the next completion
//            valid_out  - one-cycle pulse when data_out is updated
//            busy       - high while an operation is in flight
// Options  : AES_DEC_KEY_CACHE_EN - keep the last derived rk10 with its
//            cipher key; a start with the same key skips key expansion
//            (latency 10 instead of 20).
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_data,
    input  logic [127:0] key,
    input  logic         flag,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_decrypt_iter: only NR = 10 (AES-128) is supported");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_KEXP  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;

    // ---------------------------------------------------------------- GF(2^8)
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = f_xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 naturally).
    function automatic logic [7:0] f_ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = f_gmul(r, base);
            base = f_gmul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = f_ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return f_ginv(b);
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] f_sub_rot(input logic [31:0] w);
        return {f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0]), f_sbox(w[31:24])};
    endfunction

    // ------------------------------------------------------- key schedule
    function automatic logic [127:0] f_fwd_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ f_sub_rot(rk[31:0]) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Walks one round key backwards; w3 of the older key must be rebuilt
    // first because the g-function of word 0 depends on it.
    function automatic logic [127:0] f_inv_key(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ f_sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey (+ InvMixColumns unless last).
    function automatic logic [127:0] f_inv_round(input logic [127:0] s, input logic [127:0] rk,
                                                 input logic last);
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[r+4*c] = f_inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8])
                         ^ rk[127-8*(r+4*c) -: 8];
            end
        end
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c];   a1 = b[4*c+1];
                a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = f_gmul(a0, 8'h0e) ^ f_gmul(a1, 8'h0b) ^ f_gmul(a2, 8'h0d) ^ f_gmul(a3, 8'h09);
                b[4*c+1] = f_gmul(a0, 8'h09) ^ f_gmul(a1, 8'h0e) ^ f_gmul(a2, 8'h0b) ^ f_gmul(a3, 8'h0d);
                b[4*c+2] = f_gmul(a0, 8'h0d) ^ f_gmul(a1, 8'h09) ^ f_gmul(a2, 8'h0e) ^ f_gmul(a3, 8'h0b);
                b[4*c+3] = f_gmul(a0, 8'h0b) ^ f_gmul(a1, 8'h0d) ^ f_gmul(a2, 8'h09) ^ f_gmul(a3, 8'h0e);
            end
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[k];
        return o;
    endfunction

    // ------------------------------------------------------------ datapath
    logic [1:0]   r_fsm;
    logic [3:0]   r_cnt;      // KEXP: key index being produced; ROUND: round r
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_data_out;
    logic         r_valid;
    logic         r_busy;

    logic [127:0] w_rk_fwd;
    logic [127:0] w_rk_inv;
    logic [127:0] w_round;
    logic         w_cache_hit;
    logic [127:0] w_cache_rk;

    assign w_rk_fwd = f_fwd_key(r_rk, f_rcon(r_cnt));
    // Stepping rk(r+1) -> rk(r) undoes the Rcon of round r+1.
    assign w_rk_inv = f_inv_key(r_rk, f_rcon(r_cnt + 4'd1));
    assign w_round  = f_inv_round(r_state, w_rk_inv, r_cnt == 4'd0);

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] r_key_hold;
    logic [127:0] r_cache_key;
    logic [127:0] r_cache_rk;
    logic         r_cache_vld;

    assign w_cache_hit = r_cache_vld && (key == r_cache_key);
    assign w_cache_rk  = r_cache_rk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cache_vld <= 1'b0;
        end else begin
            if (r_fsm == S_IDLE && flag) r_key_hold <= key;
            if (r_fsm == S_KEXP && r_cnt == 4'd10) begin
                r_cache_vld <= 1'b1;
                r_cache_key <= r_key_hold;
                r_cache_rk  <= w_rk_fwd;
            end
        end
    end
`else
    assign w_cache_hit = 1'b0;
    assign w_cache_rk  = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm      <= S_IDLE;
            r_cnt      <= 4'd0;
            r_state    <= '0;
            r_rk       <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (flag) begin
                        r_busy <= 1'b1;
                        if (w_cache_hit) begin
                            r_state <= in_data ^ w_cache_rk;
                            r_rk    <= w_cache_rk;
                            r_cnt   <= 4'd9;
                            r_fsm   <= S_ROUND;
                        end else begin
                            r_state <= in_data;
                            r_rk    <= key;
                            r_cnt   <= 4'd1;
                            r_fsm   <= S_KEXP;
                        end
                    end
                end
                S_KEXP: begin
                    r_rk <= w_rk_fwd;
                    if (r_cnt == 4'd10) begin
                        r_state <= r_state ^ w_rk_fwd;
                        r_cnt   <= 4'd9;
                        r_fsm   <= S_ROUND;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_ROUND: begin
                    r_state <= w_round;
                    r_rk    <= w_rk_inv;
                    if (r_cnt == 4'd0) begin
                        r_data_out <= w_round;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_fsm      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_iter
// Purpose  : Self-checking bench for aes_decrypt_iter. A forward AES-128
//            reference (full key schedule, table S-box derived by brute-force
//            field inversion) encrypts random plaintexts; the DUT must return
//            them. FIPS vectors, busy rejection, back-to-back, mid-op reset
//            and key-cache latency are covered. Honours AES_DEC_KEY_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_iter;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] key = '0;
    logic         flag = 1'b0;
    logic [127:0] data_out;
    logic         valid_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // key-cache model
    bit           m_cvld = 1'b0;
    logic [127:0] m_ckey = '0;

    logic [7:0] sb [256];

    aes_decrypt_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .key       (key),
        .flag      (flag),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x8, s;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_mul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
                    ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] kk);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
                    s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic int exp_lat(input logic [127:0] kk);
        return (CACHE_EN && m_cvld && kk == m_ckey) ? 10 : 20;
    endfunction

    function automatic void note_done(input logic [127:0] kk);
        m_cvld = 1'b1;
        m_ckey = kk;
    endfunction

    // ---------------------------------------------------------- drivers
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flag  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_cvld = 1'b0;
    endtask

    // Launches one op and waits (bounded) for valid_out. lat = -1 on timeout.
    task automatic run_op(input logic [127:0] ct, input logic [127:0] kk,
                          output int lat, output logic [127:0] pt, output bit busy_gap);
        @(negedge clk);
        in_data = ct;
        key     = kk;
        flag    = 1'b1;
        @(negedge clk);
        flag     = 1'b0;
        lat      = -1;
        pt       = '0;
        busy_gap = !busy;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (valid_out) begin
                lat = c;
                pt  = data_out;
                break;
            end
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fips(input logic [127:0] ct, input logic [127:0] kk, input logic [127:0] exp_pt,
                             input string nm);
        int lat, e;
        logic [127:0] pt;
        bit gap;
        e = exp_lat(kk);
        run_op(ct, kk, lat, pt, gap);
        note_done(kk);
        n_checks++;
        if (pt !== exp_pt) begin n_fail++; $display("FAIL %s_data: got %h expected %h", nm, pt, exp_pt); end
        n_checks++;
        if (lat !== e) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, e); end
        n_checks++;
        if (gap !== 1'b0) begin n_fail++; $display("FAIL %s_busy_gap: busy dropped before completion", nm); end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_valid_width: got %b expected 0", nm, valid_out); end
        n_checks++;
        if (data_out !== exp_pt) begin n_fail++; $display("FAIL %s_hold: got %h expected %h", nm, data_out, exp_pt); end
    endtask

    task automatic test_random();
        logic [127:0] pt, ct, kk, got;
        int lat, e;
        bit gap;
        kk = '0;
        for (int it = 0; it < 6; it++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            if (it % 3 != 2) kk = {$urandom, $urandom, $urandom, $urandom};
            ct = m_encrypt(pt, kk);
            e  = exp_lat(kk);
            run_op(ct, kk, lat, got, gap);
            note_done(kk);
            n_checks++;
            if (got !== pt) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", it, got, pt); end
            n_checks++;
            if (lat !== e) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, e); end
        end
    endtask

    task automatic test_busy_reject();
        int pulses, plat, e;
        bit seen_b;
        logic [127:0] got;
        e = exp_lat(C1_KEY);
        pulses = 0; plat = -1; seen_b = 1'b0; got = '0;
        @(negedge clk);
        in_data = C1_CT; key = C1_KEY; flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (valid_out) begin pulses++; plat = c; got = data_out; end
            if (data_out === B_PT) seen_b = 1'b1;
            if (c == 4) begin in_data = B_CT; key = B_KEY; flag = 1'b1; end
            if (c == 5) flag = 1'b0;
        end
        note_done(C1_KEY);
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL busy_reject_pulses: got %0d expected 1", pulses); end
        n_checks++;
        if (got !== C1_PT) begin n_fail++; $display("FAIL busy_reject_data: got %h expected %h", got, C1_PT); end
        n_checks++;
        if (seen_b !== 1'b0) begin n_fail++; $display("FAIL busy_reject_leak: data_out showed B plaintext"); end
        n_checks++;
        if (plat !== e) begin n_fail++; $display("FAIL busy_reject_latency: got %0d expected %0d", plat, e); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, e1, e2;
        logic [127:0] got;
        e1 = exp_lat(C1_KEY);
        lat1 = -1; lat2 = -1; got = '0;
        @(negedge clk);
        in_data = C1_CT; key = C1_KEY; flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (valid_out) begin lat1 = c; break; end
        end
        n_checks++;
        if (lat1 !== e1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat1, e1); end
        n_checks++;
        if (data_out !== C1_PT) begin n_fail++; $display("FAIL b2b_first_data: got %h expected %h", data_out, C1_PT); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_valid: got %b expected 0", busy); end
        note_done(C1_KEY);
        e2 = exp_lat(B_KEY);
        in_data = B_CT; key = B_KEY; flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_after: got %b expected 1", busy); end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (valid_out) begin lat2 = c; got = data_out; break; end
        end
        note_done(B_KEY);
        n_checks++;
        if (lat2 !== e2) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat2, e2); end
        n_checks++;
        if (got !== B_PT) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", got, B_PT); end
    endtask

    task automatic test_reset_mid_op();
        int pulses, lat;
        logic [127:0] pt;
        bit gap;
        do_reset();
        pulses = 0;
        @(negedge clk);
        in_data = C1_CT; key = C1_KEY; flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        m_cvld = 1'b0;
        n_checks++;
        if (data_out !== 128'h0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", data_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (valid_out) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", pulses); end
        run_op(C1_CT, C1_KEY, lat, pt, gap);
        note_done(C1_KEY);
        n_checks++;
        if (pt !== C1_PT) begin n_fail++; $display("FAIL midreset_fresh_data: got %h expected %h", pt, C1_PT); end
        n_checks++;
        if (lat !== 20) begin n_fail++; $display("FAIL midreset_fresh_latency: got %0d expected 20", lat); end
    endtask

    task automatic test_key_cache();
        int lat;
        logic [127:0] pt;
        bit gap;
        int exp_seq [5];
        exp_seq[0] = 20;
        exp_seq[1] = CACHE_EN ? 10 : 20;
        exp_seq[2] = 20;
        exp_seq[3] = 20;
        exp_seq[4] = CACHE_EN ? 10 : 20;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) do_reset();
            if (i == 2) run_op(B_CT, B_KEY, lat, pt, gap);
            else        run_op(C1_CT, C1_KEY, lat, pt, gap);
            n_checks++;
            if (lat !== exp_seq[i]) begin
                n_fail++; $display("FAIL cache_step%0d_latency: got %0d expected %0d", i, lat, exp_seq[i]);
            end
            n_checks++;
            if (pt !== ((i == 2) ? B_PT : C1_PT)) begin
                n_fail++; $display("FAIL cache_step%0d_data: got %h", i, pt);
            end
        end
        note_done(C1_KEY);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips(C1_CT, C1_KEY, C1_PT, "fips_c1");
        test_fips(B_CT, B_KEY, B_PT, "fips_b");
        test_random();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_op();
        test_key_cache();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
